// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage LEGv8 pipeline. It merges the data-memory freeze,
// the taken-branch flush and load-use bubble requests into one prioritised set of controls.
module pipeline_hazard_controller #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_RegisterRd,
    input  logic [4:0]       IFID_RegisterRn,
    input  logic [4:0]       IFID_RegisterRm,
    input  logic             EXMEM_BranchTaken,
    input  logic             DMEM_Req,
    input  logic             DMEM_Ready,
    input  logic             CountClear,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Flush,
    output logic             Pipe_Freeze,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount,
    output logic [1:0]       State
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOADUSE = 2'd1,
        MEMWAIT = 2'd2,
        UNUSED  = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        cond_f;
    logic        cond_b;
    logic        cond_l;
    logic        stall_inc;
    logic        flush_inc;
    logic [15:0] wait_cnt;
    logic [16:0] wait_inc;

    // X31 is XZR, so a load targeting it never creates a real dependency.
    always_comb begin
        cond_f = DMEM_Req & ~DMEM_Ready;
        cond_b = EXMEM_BranchTaken;
        cond_l = IDEX_MemRead
               & (IDEX_RegisterRd != 5'd31)
               & ((IDEX_RegisterRd == IFID_RegisterRn) | (IDEX_RegisterRd == IFID_RegisterRm))
               & (state != LOADUSE);
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        next_state  = RUN;
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        EXMEM_Flush = 1'b0;
        Pipe_Freeze = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (cond_f) begin
            next_state  = MEMWAIT;
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            Pipe_Freeze = 1'b1;
            stall_inc   = 1'b1;
        end else if (cond_b) begin
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
            flush_inc   = 1'b1;
        end else if (cond_l) begin
            next_state  = LOADUSE;
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Flush  = 1'b1;
            stall_inc   = 1'b1;
        end

        // Hold the front end and keep bubbles flowing for as long as reset is asserted.
        if (!RESET_N) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
            Pipe_Freeze = 1'b0;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else if (CountClear) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (stall_inc && (StallCycles != '1)) begin
                StallCycles <= StallCycles + CNT_W'(1);
            end
            if (flush_inc && (FlushCount != '1)) begin
                FlushCount <= FlushCount + CNT_W'(1);
            end
        end
    end

    // wait_cnt counts consecutive frozen cycles; it saturates so MemTimeout can never be missed.
    assign wait_inc = {1'b0, wait_cnt} + 17'd1;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            wait_cnt   <= '0;
            MemTimeout <= 1'b0;
        end else if (cond_f) begin
            if (wait_cnt != '1) begin
                wait_cnt <= wait_inc[15:0];
            end
            if (wait_inc >= 17'(MEM_TIMEOUT)) begin
                MemTimeout <= 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    assign State = state;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: one default-sized instance and one
// small instance (CNT_W=4, MEM_TIMEOUT=3), both compared against a behavioural model.
module tb_pipeline_hazard_controller;

    localparam int TO_A  = 255;
    localparam int TO_B  = 3;
    localparam int MAX_A = 65535;
    localparam int MAX_B = 15;

    logic       CLOCK = 1'b0;
    logic       RESET_N;
    logic       IDEX_MemRead;
    logic [4:0] IDEX_RegisterRd;
    logic [4:0] IFID_RegisterRn;
    logic [4:0] IFID_RegisterRm;
    logic       EXMEM_BranchTaken;
    logic       DMEM_Req;
    logic       DMEM_Ready;
    logic       CountClear;

    logic        pc_a, ifw_a, iff_a, idf_a, emf_a, frz_a, to_a;
    logic [15:0] stall_a, flush_a;
    logic [1:0]  state_a;
    logic        pc_b, ifw_b, iff_b, idf_b, emf_b, frz_b, to_b;
    logic [3:0]  stall_b, flush_b;
    logic [1:0]  state_b;
    logic [5:0]  ctl_a, ctl_b;

    int tests = 0;
    int fails = 0;

    always #5 CLOCK = ~CLOCK;

    pipeline_hazard_controller dut_a (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_RegisterRd(IDEX_RegisterRd),
        .IFID_RegisterRn(IFID_RegisterRn), .IFID_RegisterRm(IFID_RegisterRm),
        .EXMEM_BranchTaken(EXMEM_BranchTaken), .DMEM_Req(DMEM_Req),
        .DMEM_Ready(DMEM_Ready), .CountClear(CountClear),
        .PCWrite(pc_a), .IFID_Write(ifw_a), .IFID_Flush(iff_a), .IDEX_Flush(idf_a),
        .EXMEM_Flush(emf_a), .Pipe_Freeze(frz_a), .MemTimeout(to_a),
        .StallCycles(stall_a), .FlushCount(flush_a), .State(state_a)
    );

    pipeline_hazard_controller #(.CNT_W(4), .MEM_TIMEOUT(TO_B)) dut_b (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_RegisterRd(IDEX_RegisterRd),
        .IFID_RegisterRn(IFID_RegisterRn), .IFID_RegisterRm(IFID_RegisterRm),
        .EXMEM_BranchTaken(EXMEM_BranchTaken), .DMEM_Req(DMEM_Req),
        .DMEM_Ready(DMEM_Ready), .CountClear(CountClear),
        .PCWrite(pc_b), .IFID_Write(ifw_b), .IFID_Flush(iff_b), .IDEX_Flush(idf_b),
        .EXMEM_Flush(emf_b), .Pipe_Freeze(frz_b), .MemTimeout(to_b),
        .StallCycles(stall_b), .FlushCount(flush_b), .State(state_b)
    );

    // Control bundle order: PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, Pipe_Freeze.
    assign ctl_a = {pc_a, ifw_a, iff_a, idf_a, emf_a, frz_a};
    assign ctl_b = {pc_b, ifw_b, iff_b, idf_b, emf_b, frz_b};

    localparam logic [5:0] CTL_RESET  = 6'b001110;
    localparam logic [5:0] CTL_RUN    = 6'b110000;
    localparam logic [5:0] CTL_BUBBLE = 6'b000100;
    localparam logic [5:0] CTL_BRANCH = 6'b111110;
    localparam logic [5:0] CTL_FREEZE = 6'b000001;

    // Behavioural model: mode 0 = running, 1 = just inserted a bubble, 2 = waiting on memory.
    int m_state;
    int m_stall_a, m_flush_a, m_stall_b, m_flush_b;
    int m_wait;
    bit m_to_a, m_to_b;

    typedef struct {
        logic [5:0] ctl;
        int         nxt;
        bit         stall;
        bit         flush;
    } exp_t;

    function automatic exp_t model_comb();
        exp_t e;
        bit f, b, l;
        f = DMEM_Req && !DMEM_Ready;
        b = EXMEM_BranchTaken;
        l = IDEX_MemRead && (IDEX_RegisterRd != 5'd31)
            && (IDEX_RegisterRd == IFID_RegisterRn || IDEX_RegisterRd == IFID_RegisterRm)
            && (m_state != 1);
        e.stall = 1'b0;
        e.flush = 1'b0;
        if (f) begin
            e.ctl = CTL_FREEZE; e.nxt = 2; e.stall = 1'b1;
        end else if (b) begin
            e.ctl = CTL_BRANCH; e.nxt = 0; e.flush = 1'b1;
        end else if (l) begin
            e.ctl = CTL_BUBBLE; e.nxt = 1; e.stall = 1'b1;
        end else begin
            e.ctl = CTL_RUN; e.nxt = 0;
        end
        if (!RESET_N) e.ctl = CTL_RESET;
        return e;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_stall_a = 0; m_flush_a = 0; m_stall_b = 0; m_flush_b = 0;
        m_wait = 0; m_to_a = 1'b0; m_to_b = 1'b0;
    endtask

    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rn,
                         input logic [4:0] rm, input logic bt, input logic req,
                         input logic rdy, input logic clr);
        IDEX_MemRead = mr; IDEX_RegisterRd = rd; IFID_RegisterRn = rn; IFID_RegisterRm = rm;
        EXMEM_BranchTaken = bt; DMEM_Req = req; DMEM_Ready = rdy; CountClear = clr;
        #1;
    endtask

    // Advance one clock edge and move the model along with it; returns on the next falling edge.
    task automatic tick();
        exp_t e;
        e = model_comb();
        @(posedge CLOCK);
        if (CountClear) begin
            m_stall_a = 0; m_flush_a = 0; m_stall_b = 0; m_flush_b = 0;
        end else begin
            if (e.stall) begin
                if (m_stall_a < MAX_A) m_stall_a++;
                if (m_stall_b < MAX_B) m_stall_b++;
            end
            if (e.flush) begin
                if (m_flush_a < MAX_A) m_flush_a++;
                if (m_flush_b < MAX_B) m_flush_b++;
            end
        end
        if (e.stall && e.ctl == CTL_FREEZE) begin
            if (m_wait < 65535) m_wait++;
            if (m_wait >= TO_A) m_to_a = 1'b1;
            if (m_wait >= TO_B) m_to_b = 1'b1;
        end else begin
            m_wait = 0;
        end
        m_state = e.nxt;
        @(negedge CLOCK);
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        RESET_N = 1'b0;
        #1;
        model_reset();
        @(negedge CLOCK);
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        model_reset();
        tests++; if (ctl_a !== CTL_RESET) begin fails++; $display("FAIL reset_ctl_a got %b want %b", ctl_a, CTL_RESET); end
        tests++; if (ctl_b !== CTL_RESET) begin fails++; $display("FAIL reset_ctl_b got %b want %b", ctl_b, CTL_RESET); end
        tests++; if (state_a !== 2'd0 || stall_a !== 16'd0 || flush_a !== 16'd0 || to_a !== 1'b0) begin
            fails++; $display("FAIL reset_regs got state=%0d stall=%0d flush=%0d to=%b want 0 0 0 0", state_a, stall_a, flush_a, to_a);
        end
        @(negedge CLOCK);
        RESET_N = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (ctl_a !== CTL_RUN) begin fails++; $display("FAIL post_reset_ctl got %b want %b", ctl_a, CTL_RUN); end
    endtask

    task automatic test_load_use();
        drive(1'b1, 5'd3, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (ctl_a !== CTL_BUBBLE) begin fails++; $display("FAIL load_use_ctl got %b want %b", ctl_a, CTL_BUBBLE); end
        tick();
        tests++; if (state_a !== 2'd1) begin fails++; $display("FAIL load_use_state got %0d want 1", state_a); end
        tests++; if (stall_a !== 16'd1 || stall_b !== 4'd1) begin fails++; $display("FAIL load_use_count got %0d/%0d want 1/1", stall_a, stall_b); end
        tests++; if (ctl_a !== CTL_RUN) begin fails++; $display("FAIL load_use_masked got %b want %b", ctl_a, CTL_RUN); end
        tick();
        tests++; if (state_a !== 2'd0 || stall_a !== 16'd1) begin fails++; $display("FAIL load_use_once got state=%0d stall=%0d want 0 1", state_a, stall_a); end
    endtask

    task automatic test_xzr();
        drive(1'b1, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (ctl_a !== CTL_RUN) begin fails++; $display("FAIL xzr_ctl got %b want %b", ctl_a, CTL_RUN); end
        tick();
        tests++; if (stall_a !== 16'd1 || state_a !== 2'd0) begin fails++; $display("FAIL xzr_regs got stall=%0d state=%0d want 1 0", stall_a, state_a); end
    endtask

    task automatic test_branch_over_load();
        drive(1'b1, 5'd5, 5'd9, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++; if (ctl_a !== CTL_BRANCH) begin fails++; $display("FAIL branch_ctl got %b want %b", ctl_a, CTL_BRANCH); end
        tick();
        tests++; if (flush_a !== 16'd1 || stall_a !== 16'd1 || state_a !== 2'd0) begin
            fails++; $display("FAIL branch_regs got flush=%0d stall=%0d state=%0d want 1 1 0", flush_a, stall_a, state_a);
        end
    endtask

    task automatic test_memwait_branch();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tests++; if (stall_a !== 16'd0 || flush_a !== 16'd0) begin fails++; $display("FAIL clear got %0d/%0d want 0/0", stall_a, flush_a); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd2, 5'd2, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
            tests++; if (ctl_a !== CTL_FREEZE) begin fails++; $display("FAIL memwait_ctl[%0d] got %b want %b", i, ctl_a, CTL_FREEZE); end
            tick();
            tests++; if (state_a !== 2'd2) begin fails++; $display("FAIL memwait_state[%0d] got %0d want 2", i, state_a); end
        end
        drive(1'b1, 5'd2, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        tests++; if (ctl_a !== CTL_BRANCH) begin fails++; $display("FAIL ready_branch_ctl got %b want %b", ctl_a, CTL_BRANCH); end
        tick();
        tests++; if (stall_a !== 16'd4 || flush_a !== 16'd1 || state_a !== 2'd0) begin
            fails++; $display("FAIL ready_regs got stall=%0d flush=%0d state=%0d want 4 1 0", stall_a, flush_a, state_a);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
            tests++; if (to_b !== (k >= TO_B)) begin fails++; $display("FAIL timeout_b[%0d] got %b want %b", k, to_b, k >= TO_B); end
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tests++; if (to_b !== 1'b1 || to_a !== 1'b0 || state_a !== 2'd0) begin
            fails++; $display("FAIL timeout_sticky got b=%b a=%b state=%0d want 1 0 0", to_b, to_a, state_a);
        end
        do_reset();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < TO_A; k++) tick();
        tests++; if (to_a !== 1'b0) begin fails++; $display("FAIL timeout_a_early got %b want 0", to_a); end
        tick();
        tests++; if (to_a !== 1'b1) begin fails++; $display("FAIL timeout_a_edge got %b want 1", to_a); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 5'd4, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        tests++; if (stall_b !== 4'd15 || stall_a !== 16'd20) begin fails++; $display("FAIL stall_sat got b=%0d a=%0d want 15 20", stall_b, stall_a); end
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        tests++; if (flush_b !== 4'd15 || flush_a !== 16'd20) begin fails++; $display("FAIL flush_sat got b=%0d a=%0d want 15 20", flush_b, flush_a); end
        drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tests++; if (stall_b !== 4'd0 || stall_a !== 16'd0 || flush_b !== 4'd0) begin
            fails++; $display("FAIL clear_wins got b=%0d a=%0d fb=%0d want 0 0 0", stall_b, stall_a, flush_b);
        end
    endtask

    task automatic test_reset_mid_memwait();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tests++; if (state_a !== 2'd2) begin fails++; $display("FAIL pre_reset_state got %0d want 2", state_a); end
        #2 RESET_N = 1'b0;
        #1;
        model_reset();
        tests++; if (state_a !== 2'd0 || state_b !== 2'd0) begin fails++; $display("FAIL async_reset_state got %0d/%0d want 0/0", state_a, state_b); end
        tests++; if (ctl_a !== CTL_RESET) begin fails++; $display("FAIL async_reset_ctl got %b want %b", ctl_a, CTL_RESET); end
        tests++; if (stall_a !== 16'd0 || to_b !== 1'b0) begin fails++; $display("FAIL async_reset_regs got stall=%0d to=%b want 0 0", stall_a, to_b); end
        @(negedge CLOCK);
        RESET_N = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (ctl_a !== CTL_RUN || state_a !== 2'd0) begin fails++; $display("FAIL after_reset got ctl=%b state=%0d want %b 0", ctl_a, state_a, CTL_RUN); end
        tick();
    endtask

    task automatic test_random();
        exp_t e;
        logic [4:0] regs [5];
        regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd2; regs[3] = 5'd3; regs[4] = 5'd31;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)],
                  regs[$urandom_range(0, 4)], ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
            e = model_comb();
            tests++; if (ctl_a !== e.ctl || ctl_b !== e.ctl) begin
                fails++; $display("FAIL rand_ctl[%0d] got %b/%b want %b", i, ctl_a, ctl_b, e.ctl);
            end
            tests++; if (state_a !== 2'(m_state) || state_b !== 2'(m_state)) begin
                fails++; $display("FAIL rand_state[%0d] got %0d/%0d want %0d", i, state_a, state_b, m_state);
            end
            tests++; if (stall_a !== 16'(m_stall_a) || flush_a !== 16'(m_flush_a) ||
                         stall_b !== 4'(m_stall_b) || flush_b !== 4'(m_flush_b)) begin
                fails++; $display("FAIL rand_counts[%0d] got %0d %0d %0d %0d want %0d %0d %0d %0d", i,
                                  stall_a, flush_a, stall_b, flush_b, m_stall_a, m_flush_a, m_stall_b, m_flush_b);
            end
            tests++; if (to_a !== m_to_a || to_b !== m_to_b) begin
                fails++; $display("FAIL rand_timeout[%0d] got %b/%b want %b/%b", i, to_a, to_b, m_to_a, m_to_b);
            end
            tick();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_xzr();
        test_branch_over_load();
        test_memwait_branch();
        test_timeout();
        test_saturation();
        test_reset_mid_memwait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
